mem_arbiter: RTL and testbench

Round-robin arbiter that shares one single-port synchronous memory among `NUM_REQ` processor-side requesters: instruction fetch, data load/store, and the framebuffer reader. It grants at most one request per cycle and drives the memory command from the winning requester. It then routes each read response back to its issuer after the fixed memory read latency. It sits between the pipelined core's fetch/memory stages and the shared BRAM.

---
 rtl/mem_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory among NUM_REQ requesters.
// Define MEM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module mem_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ-1:0]            req_we_i,
    input  logic [NUM_REQ*ADDR_W-1:0]     req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0]     req_wdata_i,
    input  logic [NUM_REQ*DATA_W/8-1:0]   req_wstrb_i,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    output logic [DATA_W-1:0]             rsp_rdata_o,
    output logic                          mem_en_o,
    output logic [DATA_W/8-1:0]           mem_we_o,
    output logic [ADDR_W-1:0]             mem_addr_o,
    output logic [DATA_W-1:0]             mem_wdata_o,
    input  logic [DATA_W-1:0]             mem_rdata_i
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = $clog2(NUM_REQ);

    logic [IDX_W-1:0] start_idx;
    logic             grant_vld;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] cand_idx;
    int               cand;
    logic             rd_grant;

    logic             vld_p [RD_LATENCY];
    logic [IDX_W-1:0] idx_p [RD_LATENCY];

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign start_idx = '0;
`else
    logic [IDX_W-1:0] rr_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rr_q <= '0;
        end else if (grant_vld) begin
            rr_q <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    assign start_idx = rr_q;
`endif

    // Scan from start_idx, wrapping modulo NUM_REQ; first valid requester wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(start_idx) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!grant_vld && req_valid_i[cand_idx]) begin
                grant_vld = 1'b1;
                grant_idx = cand_idx;
            end
        end
        grant_vld = grant_vld & ~reset_i;
    end

    // Command stage: combinational from the winner straight to the memory.
    always_comb begin
        req_ready_o = '0;
        mem_en_o    = grant_vld;
        mem_we_o    = '0;
        mem_addr_o  = req_addr_i[int'(grant_idx)*ADDR_W +: ADDR_W];
        mem_wdata_o = req_wdata_i[int'(grant_idx)*DATA_W +: DATA_W];
        if (grant_vld) begin
            req_ready_o[grant_idx] = 1'b1;
            if (req_we_i[grant_idx]) begin
                mem_we_o = req_wstrb_i[int'(grant_idx)*STRB_W +: STRB_W];
            end
        end
    end

    assign rd_grant = grant_vld & ~req_we_i[grant_idx];

    // Read-ID pipeline: tracks which requester owns the data RD_LATENCY cycles later.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int s = 0; s < RD_LATENCY; s++) begin
                vld_p[s] <= 1'b0;
            end
        end else begin
            vld_p[0] <= rd_grant;
            for (int s = 1; s < RD_LATENCY; s++) begin
                vld_p[s] <= vld_p[s-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        idx_p[0] <= grant_idx;
        for (int s = 1; s < RD_LATENCY; s++) begin
            idx_p[s] <= idx_p[s-1];
        end
    end

    // Response stage: steer the memory data to the issuer of the tail entry.
    always_comb begin
        rsp_valid_o = '0;
        if (vld_p[RD_LATENCY-1]) begin
            rsp_valid_o[idx_p[RD_LATENCY-1]] = 1'b1;
        end
    end

    assign rsp_rdata_o = mem_rdata_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances (read latency 1, 2, 3) share one stimulus
// and one behavioural memory whose read data is tapped at each latency.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  req_valid;
    logic [2:0]  req_we;
    logic [95:0] req_addr;
    logic [95:0] req_wdata;
    logic [11:0] req_wstrb;

    logic [2:0]  ready1, ready2, ready3;
    logic [2:0]  rsp1, rsp2, rsp3;
    logic [31:0] rdat1, rdat2, rdat3;
    logic        en1, en2, en3;
    logic [3:0]  we1, we2, we3;
    logic [31:0] addr1, addr2, addr3;
    logic [31:0] wd1, wd2, wd3;

    logic [31:0] mem [0:63];
    logic [31:0] rd_p0, rd_p1, rd_p2;
    logic        pl_en;
    logic [5:0]  pl_idx;
    logic [31:0] pl_data;

    int n_vec;
    int n_err;

    mem_arbiter #(.NUM_REQ(3), .ADDR_W(32), .DATA_W(32), .RD_LATENCY(1)) u_dut (
        .clk_i(clk), .reset_i(rst), .req_valid_i(req_valid), .req_ready_o(ready1),
        .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .req_wstrb_i(req_wstrb), .rsp_valid_o(rsp1), .rsp_rdata_o(rdat1),
        .mem_en_o(en1), .mem_we_o(we1), .mem_addr_o(addr1), .mem_wdata_o(wd1),
        .mem_rdata_i(rd_p0)
    );

    mem_arbiter #(.NUM_REQ(3), .ADDR_W(32), .DATA_W(32), .RD_LATENCY(2)) u_lat2 (
        .clk_i(clk), .reset_i(rst), .req_valid_i(req_valid), .req_ready_o(ready2),
        .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .req_wstrb_i(req_wstrb), .rsp_valid_o(rsp2), .rsp_rdata_o(rdat2),
        .mem_en_o(en2), .mem_we_o(we2), .mem_addr_o(addr2), .mem_wdata_o(wd2),
        .mem_rdata_i(rd_p1)
    );

    mem_arbiter #(.NUM_REQ(3), .ADDR_W(32), .DATA_W(32), .RD_LATENCY(3)) u_lat3 (
        .clk_i(clk), .reset_i(rst), .req_valid_i(req_valid), .req_ready_o(ready3),
        .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .req_wstrb_i(req_wstrb), .rsp_valid_o(rsp3), .rsp_rdata_o(rdat3),
        .mem_en_o(en3), .mem_we_o(we3), .mem_addr_o(addr3), .mem_wdata_o(wd3),
        .mem_rdata_i(rd_p2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory driven by the latency-1 instance; all instances see identical commands.
    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_idx] <= pl_data;
        end else if (en1 && we1 != 4'b0000) begin
            for (int b = 0; b < 4; b++) begin
                if (we1[b]) mem[addr1[7:2]][8*b +: 8] <= wd1[8*b +: 8];
            end
        end
        if (en1 && we1 == 4'b0000) rd_p0 <= mem[addr1[7:2]];
        rd_p1 <= rd_p0;
        rd_p2 <= rd_p1;
    end

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = a[7:2]; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic idle(input int n);
        req_valid = 3'b000;
        req_we    = 3'b000;
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_pulse();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        req_valid = 3'b111;
        #1;
        n_vec++; if (ready1 !== 3'b000) begin n_err++; $display("FAIL reset_ready: got %b want 000", ready1); end
        n_vec++; if (en1 !== 1'b0) begin n_err++; $display("FAIL reset_en: got %b want 0", en1); end
        n_vec++; if (we1 !== 4'b0000) begin n_err++; $display("FAIL reset_we: got %b want 0000", we1); end
        n_vec++; if (rsp1 !== 3'b000 || rsp3 !== 3'b000) begin n_err++; $display("FAIL reset_rsp: got %b/%b want 000/000", rsp1, rsp3); end
        req_valid = 3'b000;
        preload(32'h10, 32'hDEADBEEF);
        preload(32'h20, 32'hAABBCCDD);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        @(negedge clk);
        req_valid = 3'b010; req_we = 3'b000; req_addr[32 +: 32] = 32'h10;
        #1;
        n_vec++; if (ready1 !== 3'b010) begin n_err++; $display("FAIL single_ready: got %b want 010", ready1); end
        n_vec++; if (en1 !== 1'b1 || addr1 !== 32'h10 || we1 !== 4'b0000) begin
            n_err++; $display("FAIL single_cmd: got en=%b addr=%h we=%b want en=1 addr=10 we=0000", en1, addr1, we1); end
        @(negedge clk);
        req_valid = 3'b000;
        #1;
        n_vec++; if (rsp1 !== 3'b010) begin n_err++; $display("FAIL single_rsp: got %b want 010", rsp1); end
        n_vec++; if (rdat1 !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_rdata: got %h want deadbeef", rdat1); end
    endtask

    task automatic test_fairness();
        logic [2:0] exp_g;
        logic [2:0] exp_r;
        reset_pulse();
        req_valid = 3'b111; req_we = 3'b000;
        req_addr = {32'h108, 32'h104, 32'h100};
        for (int i = 0; i < 6; i++) begin
            #1;
            exp_g = 3'b001 << (i % 3);
            exp_r = (i == 0) ? 3'b000 : 3'b001 << ((i - 1) % 3);
            n_vec++; if (ready1 !== exp_g) begin n_err++; $display("FAIL fair_grant[%0d]: got %b want %b", i, ready1, exp_g); end
            n_vec++; if (addr1 !== 32'h100 + 32'(4 * (i % 3))) begin
                n_err++; $display("FAIL fair_addr[%0d]: got %h want %h", i, addr1, 32'h100 + 32'(4 * (i % 3))); end
            n_vec++; if (rsp1 !== exp_r) begin n_err++; $display("FAIL fair_rsp[%0d]: got %b want %b", i, rsp1, exp_r); end
            @(negedge clk);
        end
        req_valid = 3'b000;
        #1;
        n_vec++; if (rsp1 !== 3'b100) begin n_err++; $display("FAIL fair_rsp_last: got %b want 100", rsp1); end
    endtask

    task automatic test_byte_write();
        idle(4);
        req_valid = 3'b010; req_we = 3'b010;
        req_addr[32 +: 32] = 32'h20; req_wdata[32 +: 32] = 32'h11223344; req_wstrb[4 +: 4] = 4'b0011;
        #1;
        n_vec++; if (ready1 !== 3'b010) begin n_err++; $display("FAIL bw_ready: got %b want 010", ready1); end
        n_vec++; if (we1 !== 4'b0011) begin n_err++; $display("FAIL bw_we: got %b want 0011", we1); end
        n_vec++; if (wd1 !== 32'h11223344 || addr1 !== 32'h20) begin
            n_err++; $display("FAIL bw_cmd: got wdata=%h addr=%h want 11223344/20", wd1, addr1); end
        @(negedge clk);
        req_valid = 3'b001; req_we = 3'b000; req_addr[0 +: 32] = 32'h20;
        #1;
        n_vec++; if (ready1 !== 3'b001 || we1 !== 4'b0000) begin
            n_err++; $display("FAIL bw_read_cmd: got ready=%b we=%b want 001/0000", ready1, we1); end
        n_vec++; if (rsp1 !== 3'b000) begin n_err++; $display("FAIL bw_no_rsp: got %b want 000", rsp1); end
        @(negedge clk);
        req_valid = 3'b000;
        #1;
        n_vec++; if (rsp1 !== 3'b001) begin n_err++; $display("FAIL bw_rsp: got %b want 001", rsp1); end
        n_vec++; if (rdat1 !== 32'hAABB3344) begin n_err++; $display("FAIL bw_rdata: got %h want aabb3344", rdat1); end
    endtask

    task automatic test_latency();
        logic [2:0]  exp_r [6];
        logic [31:0] exp_d [6];
        exp_r = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b001, 3'b000};
        exp_d = '{32'h0, 32'h0, 32'h0, 32'hDEADBEEF, 32'hAABB3344, 32'h0};
        idle(4);
        for (int i = 0; i < 6; i++) begin
            req_we = 3'b000;
            if (i == 0) begin req_valid = 3'b100; req_addr[64 +: 32] = 32'h10; end
            else if (i == 1) begin req_valid = 3'b001; req_addr[0 +: 32] = 32'h20; end
            else req_valid = 3'b000;
            #1;
            n_vec++; if (rsp3 !== exp_r[i]) begin n_err++; $display("FAIL lat3_rsp[T+%0d]: got %b want %b", i, rsp3, exp_r[i]); end
            if (exp_r[i] != 3'b000) begin
                n_vec++; if (rdat3 !== exp_d[i]) begin n_err++; $display("FAIL lat3_rdata[T+%0d]: got %h want %h", i, rdat3, exp_d[i]); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midflight();
        idle(4);
        req_valid = 3'b010; req_we = 3'b000; req_addr[32 +: 32] = 32'h10;
        #1;
        n_vec++; if (ready2 !== 3'b010) begin n_err++; $display("FAIL rmf_grant: got %b want 010", ready2); end
        @(negedge clk);
        req_valid = 3'b000; rst = 1'b1;
        #1;
        n_vec++; if (rsp2 !== 3'b000) begin n_err++; $display("FAIL rmf_rsp_t1: got %b want 000", rsp2); end
        @(negedge clk);
        #1;
        n_vec++; if (rsp2 !== 3'b000) begin n_err++; $display("FAIL rmf_rsp_t2: got %b want 000", rsp2); end
        @(negedge clk);
        rst = 1'b0; req_valid = 3'b111;
        #1;
        n_vec++; if (ready2 !== 3'b001 || ready1 !== 3'b001) begin
            n_err++; $display("FAIL rmf_first_grant: got %b/%b want 001/001", ready2, ready1); end
        n_vec++; if (rsp2 !== 3'b000) begin n_err++; $display("FAIL rmf_rsp_t3: got %b want 000", rsp2); end
        @(negedge clk);
        req_valid = 3'b000;
        #1;
        n_vec++; if (rsp2 !== 3'b000) begin n_err++; $display("FAIL rmf_rsp_t4: got %b want 000", rsp2); end
    endtask

    task automatic test_fixed_prio();
        logic [2:0] exp_g;
        idle(4);
        reset_pulse();
        req_valid = 3'b101; req_we = 3'b000;
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            exp_g = 3'b001;
`else
            exp_g = (i % 2 == 0) ? 3'b001 : 3'b100;
`endif
            #1;
            n_vec++; if (ready1 !== exp_g) begin n_err++; $display("FAIL prio_grant[%0d]: got %b want %b", i, ready1, exp_g); end
            @(negedge clk);
        end
        idle(4);
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst = 1'b1; pl_en = 1'b0; pl_idx = '0; pl_data = '0;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        test_reset();
        test_single();
        test_fairness();
        test_byte_write();
        test_latency();
        test_reset_midflight();
        test_fixed_prio();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
